// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan path:
// segment bit positions, hex decode table, blank pattern.
package sseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  // Active-high {g..a}, indexed by nibble.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// Nibble to active-high {g..a} pattern.
// Ports: nib_i (4b hex), seg_o (7b pattern).
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/sseg_scan_mux.sv
// N-digit seven-segment scanner: refresh counter, frame snapshot,
// blanking, dp, PWM brightness, guard time.
// Ports: clk, rst_n, value, dp_mask, blank_en, bright in;
//        an, sseg (active low), frame_start out.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_LOG2   = 16,
  parameter int BRIGHT_W   = 4,
  parameter int GUARD      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_en,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_start
);

  localparam int DIG_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST =
    DIG_W'(NUM_DIGITS - 1);
  localparam logic [DIV_LOG2-1:0] TICK_MAX = '1;
  localparam logic [DIV_LOG2-1:0] GUARD_T =
    DIV_LOG2'(GUARD);

  logic [DIV_LOG2-1:0]     tick_q, tick_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    blank_en_q;
  logic [BRIGHT_W-1:0]     bright_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    fs_q;

  logic                    snap;
  logic                    lit;
  logic [3:0]              nib;
  logic                    dp_cur;
  logic                    blank_cur;
  logic                    nz;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              seg7;

  assign snap = (tick_q == TICK_MAX) && (dig_q == DIG_LAST);

  always_comb begin
    tick_d = tick_q + DIV_LOG2'(1);
    dig_d  = dig_q;
    if (tick_q == TICK_MAX) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
    end
  end

  // Scan from the top digit down so nz tells whether any
  // nibble at or above the current index is non-zero.
  always_comb begin
    nib       = 4'h0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    nz        = 1'b0;
    an_sel    = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz = nz | (value_q[4*i +: 4] != 4'h0);
      if (dig_q == DIG_W'(i)) begin
        nib       = value_q[4*i +: 4];
        dp_cur    = dp_q[i];
        blank_cur = blank_en_q && !nz && (i != 0);
        an_sel[i] = 1'b0;
      end
    end
  end

  assign lit = (tick_q >= GUARD_T) &&
    (tick_q[DIV_LOG2-1 -: BRIGHT_W] < bright_q);

  sseg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (seg7)
  );

  always_comb begin
    an_d   = '1;
    sseg_d = SSEG_BLANK;
    if (lit) begin
      an_d                = an_sel;
      sseg_d[SEG_G:SEG_A] = blank_cur ? 7'h7F : ~seg7;
      sseg_d[SEG_DP]      = ~dp_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= '0;
      dig_q      <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      blank_en_q <= 1'b0;
      bright_q   <= '0;
      an_q       <= '1;
      sseg_q     <= SSEG_BLANK;
      fs_q       <= 1'b0;
    end else begin
      tick_q <= tick_d;
      dig_q  <= dig_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      fs_q   <= snap;
      if (snap) begin
        value_q    <= value;
        dp_q       <= dp_mask;
        blank_en_q <= blank_en;
        bright_q   <= bright;
      end
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux (4 digits, 16-cycle slots,
// guard 1) with hand-computed expected patterns.
module tb_sseg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;

  int nvec;
  int nbad;
  int pos;
  int cnt;

  sseg_scan_mux #(
    .NUM_DIGITS (4),
    .DIV_LOG2   (4),
    .BRIGHT_W   (4),
    .GUARD      (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_mask     (dp_mask),
    .blank_en    (blank_en),
    .bright      (bright),
    .an          (an),
    .sseg        (sseg),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the next frame_start pulse; n = negedges waited.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    if (!frame_start) check("fs_timeout", 32'd0, 32'd1);
    pos = 0;
  endtask

  // Move to the sample showing digit d, tick t of this frame.
  task automatic at(input int d, input int t);
    int target;
    target = d * 16 + t + 1;
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic expect_out(input string tag, input int d,
                            input int t, input logic [3:0] ea,
                            input logic [7:0] es);
    at(d, t);
    check({tag, "_an"}, 32'(an), 32'(ea));
    check({tag, "_sseg"}, 32'(sseg), 32'(es));
  endtask

  // Count samples in slot d where anode d is driven low.
  task automatic count_lit(input int d, output int n);
    n = 0;
    for (int t = 0; t < 16; t++) begin
      at(d, t);
      if (an[d] == 1'b0) n++;
    end
  endtask

  initial begin
    nvec     = 0;
    nbad     = 0;
    pos      = 0;
    rst_n    = 1'b0;
    value    = 16'hBEEF;
    dp_mask  = 4'hA;
    blank_en = 1'b1;
    bright   = 4'd9;

    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_fs", 32'(frame_start), 32'h0);

    value    = 16'h1234;
    bright   = 4'd15;
    dp_mask  = 4'h0;
    blank_en = 1'b0;
    rst_n    = 1'b1;
    wait_fs(cnt);
    check("first_fs", 32'(cnt), 32'd64);

    // Scan of 1234 at full brightness.
    expect_out("scan_g0", 0, 0, 4'hF, 8'hFF);
    at(0, 0);
    check("fs_pulse", 32'(frame_start), 32'h0);
    expect_out("scan_d0", 0, 1, 4'hE, 8'h99);
    expect_out("scan_d0e", 0, 14, 4'hE, 8'h99);
    expect_out("scan_t15", 0, 15, 4'hF, 8'hFF);
    count_lit(1, cnt);
    check("scan_lit14", 32'(cnt), 32'd14);
    expect_out("scan_d2", 2, 7, 4'hB, 8'hA4);
    expect_out("scan_d3", 3, 3, 4'h7, 8'hF9);

    // Leading-zero blanking.
    value    = 16'h0050;
    blank_en = 1'b1;
    wait_fs(cnt);
    expect_out("blk_d0", 0, 5, 4'hE, 8'hC0);
    expect_out("blk_d1", 1, 5, 4'hD, 8'h92);
    expect_out("blk_d2", 2, 5, 4'hB, 8'hFF);
    expect_out("blk_d3", 3, 5, 4'h7, 8'hFF);

    value = 16'h0000;
    wait_fs(cnt);
    expect_out("zero_d0", 0, 5, 4'hE, 8'hC0);
    expect_out("zero_d1", 1, 5, 4'hD, 8'hFF);
    expect_out("zero_d3", 3, 5, 4'h7, 8'hFF);

    blank_en = 1'b0;
    wait_fs(cnt);
    expect_out("noblk_d1", 1, 5, 4'hD, 8'hC0);
    expect_out("noblk_d3", 3, 5, 4'h7, 8'hC0);

    // Snapshot coherence.
    value = 16'h1111;
    wait_fs(cnt);
    expect_out("coh_d1", 1, 3, 4'hD, 8'hF9);
    value = 16'h2222;
    expect_out("coh_d2", 2, 3, 4'hB, 8'hF9);
    expect_out("coh_d3", 3, 3, 4'h7, 8'hF9);
    wait_fs(cnt);
    check("coh_rest", 32'(cnt), 32'd12);
    expect_out("coh_new", 0, 3, 4'hE, 8'hA4);
    wait_fs(cnt);
    check("fs_period", 32'(cnt), 32'd60);
    wait_fs(cnt);
    check("fs_period64", 32'(cnt), 32'd64);

    // Brightness.
    bright = 4'd0;
    wait_fs(cnt);
    cnt = 0;
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 16; t++) begin
        at(d, t);
        if (an != 4'hF) cnt++;
      end
    end
    check("dark_lit", 32'(cnt), 32'd0);

    bright = 4'd8;
    wait_fs(cnt);
    count_lit(2, cnt);
    check("half_lit7", 32'(cnt), 32'd7);
    expect_out("half_t7", 3, 7, 4'h7, 8'hA4);
    expect_out("half_t8", 3, 8, 4'hF, 8'hFF);

    // Decimal point on a blanked digit.
    bright   = 4'd15;
    dp_mask  = 4'b0100;
    value    = 16'h0000;
    blank_en = 1'b1;
    wait_fs(cnt);
    expect_out("dp_d0", 0, 5, 4'hE, 8'hC0);
    expect_out("dp_d1", 1, 5, 4'hD, 8'hFF);
    expect_out("dp_d2", 2, 5, 4'hB, 8'h7F);
    expect_out("dp_d3", 3, 5, 4'h7, 8'hFF);

    // Mid-frame asynchronous reset.
    at(1, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_sseg", 32'(sseg), 32'hFF);
    check("arst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(cnt);
    check("arst_fs64", 32'(cnt), 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
